// File: rtl/hazard_detection_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_detection_unit_pkg
// Shared control-path definitions for the hazard detection unit:
//   - RV32I base opcodes, grouped by instruction format
//   - hazard_state_t, the memory-wait FSM state type
// ----------------------------------------------------------------------------
package hazard_detection_unit_pkg;

    // U / J formats: no source registers
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    // I format: rs1 only
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcSystem = 7'b1110011;
    // S / B formats: rs1 and rs2
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    // R format: rs1 and rs2
    localparam logic [6:0] OpcReg    = 7'b0110011;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StError
    } hazard_state_t;

endpackage

// File: rtl/hazard_detection_unit_load_use_detector.sv
// ----------------------------------------------------------------------------
// load_use_detector
// Combinational load-use hazard check for the instruction in ID.
// Ports:
//   opcode_id    in   opcode of the ID instruction
//   rs1_id       in   rs1 field of the ID instruction
//   rs2_id       in   rs2 field of the ID instruction
//   mem_read_ex  in   EX instruction is a load
//   rd_ex        in   destination of the EX instruction
//   load_use     out  ID really reads the register the EX load writes
// ----------------------------------------------------------------------------
module load_use_detector
    import hazard_detection_unit_pkg::*;
(
    input  logic [6:0] opcode_id,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       mem_read_ex,
    input  logic [4:0] rd_ex,
    output logic       load_use
);

    logic w_uses_rs1;
    logic w_uses_rs2;

    // Only fields that are true register operands may raise a hazard;
    // in U/J/I formats the "rs2" bits are immediate bits.
    always_comb begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        case (opcode_id)
            OpcReg, OpcStore, OpcBranch: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OpcImm, OpcLoad, OpcJalr, OpcSystem: begin
                w_uses_rs1 = 1'b1;
            end
            default: begin
                w_uses_rs1 = 1'b0;
                w_uses_rs2 = 1'b0;
            end
        endcase
    end

    // x0 is never a real dependency
    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((w_uses_rs1 && (rs1_id == rd_ex)) ||
                       (w_uses_rs2 && (rs2_id == rd_ex)));

endmodule

// File: rtl/hazard_detection_unit.sv
// ----------------------------------------------------------------------------
// hazard_detection_unit
// ID-stage hazard controller: memory-wait freeze (with timeout watchdog),
// taken-branch flush and load-use stall, in that priority order.
// Optional feature macro: HAZARD_PERF_EN builds the two perf counters;
// without it stall_cycles and flush_count are tied to zero.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   opcode_id, rs1_id, rs2_id   ID instruction fields
//   mem_read_ex, rd_ex          EX load information
//   branch_taken_ex             EX branch/jump resolved taken
//   mem_req_mem, mem_ack        MEM data-memory handshake
//   pc_write .. mem_wb_write    pipeline register write enables
//   id_ex_bubble, if_id_flush   NOP insertion / IF/ID clear
//   mem_timeout_err             sticky memory timeout flag
//   stall_cycles, flush_count   saturating perf counters
// ----------------------------------------------------------------------------
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_id,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             mem_read_ex,
    input  logic [4:0]       rd_ex,
    input  logic             branch_taken_ex,
    input  logic             mem_req_mem,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned     WaitW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(MEM_TIMEOUT);

    hazard_state_t    r_state;
    logic [WaitW-1:0] r_wait_cnt;
    logic             r_timeout_err;

    logic w_load_use;
    logic w_mem_stall;
    logic w_freeze;

    load_use_detector u_load_use_detector (
        .opcode_id   (opcode_id),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .mem_read_ex (mem_read_ex),
        .rd_ex       (rd_ex),
        .load_use    (w_load_use)
    );

    // An access acked in its first cycle never freezes the pipe
    assign w_mem_stall = mem_req_mem && !mem_ack;
    assign w_freeze    = (r_state != StRun) || w_mem_stall;

    // Memory-wait FSM, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StRun;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    if (w_mem_stall) begin
                        r_state    <= StMemWait;
                        r_wait_cnt <= '0;
                    end
                end
                StMemWait: begin
                    if (mem_ack) begin
                        r_state    <= StRun;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WaitLast) begin
                        r_state       <= StError;
                        r_wait_cnt    <= WaitMax;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WaitW'(1);
                    end
                end
                StError: begin
                    r_state <= StError;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    assign mem_timeout_err = r_timeout_err;

    // Control outputs; reset gates everything off combinationally
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (!rst_n || w_freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (branch_taken_ex) begin
            // ID is discarded, so any load-use match there is irrelevant
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (w_load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_write && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (if_id_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_detection_unit
// Directed stimulus with a behavioural pipeline-hazard model checked on every
// falling edge, plus literal expectations at key points of the sequence.
// ----------------------------------------------------------------------------
module tb_hazard_detection_unit;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 32;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OP     = 7'b0110011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode_id = OPIMM;
    logic [4:0]    rs1_id = '0;
    logic [4:0]    rs2_id = '0;
    logic          mem_read_ex = 1'b0;
    logic [4:0]    rd_ex = '0;
    logic          branch_taken_ex = 1'b0;
    logic          mem_req_mem = 1'b0;
    logic          mem_ack = 1'b0;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic          id_ex_bubble, if_id_flush, mem_timeout_err;
    logic [CW-1:0] stall_cycles, flush_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(
        .MEM_TIMEOUT (TIMEOUT),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode_id       (opcode_id),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .mem_read_ex     (mem_read_ex),
        .rd_ex           (rd_ex),
        .branch_taken_ex (branch_taken_ex),
        .mem_req_mem     (mem_req_mem),
        .mem_ack         (mem_ack),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_write     (id_ex_write),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_write    (mem_wb_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Which operand fields are genuine register reads for each instruction class
    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {OP, OPIMM, LOAD, JALR, SYSTEM, STORE, BRANCH};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {OP, STORE, BRANCH};
    endfunction

    bit      m_waiting = 0;     // a memory access is outstanding past its first cycle
    int      m_waited  = 0;     // cycles spent waiting past the first
    bit      m_err     = 0;
    longint  m_stalls  = 0;
    longint  m_flushes = 0;
    bit      m_frozen, m_hazard;
    logic [6:0] m_exp;          // {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush}

    always @(negedge clk) begin
        if (!rst_n) begin
            m_waiting = 0;
            m_waited  = 0;
            m_err     = 0;
            m_stalls  = 0;
            m_flushes = 0;
            m_exp     = 7'b0000000;
        end else begin
            m_frozen = m_err || m_waiting || (mem_req_mem && !mem_ack);
            m_hazard = mem_read_ex && rd_ex != 0 &&
                       ((reads_rs1(opcode_id) && rs1_id == rd_ex) ||
                        (reads_rs2(opcode_id) && rs2_id == rd_ex));
            if (m_frozen)             m_exp = 7'b00000_00;
            else if (branch_taken_ex) m_exp = 7'b11111_11;
            else if (m_hazard)        m_exp = 7'b00111_10;
            else                      m_exp = 7'b11111_00;
        end
        check("ctrl", {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                       id_ex_bubble, if_id_flush}, m_exp);
        check("timeout_err", mem_timeout_err, m_err);
`ifdef HAZARD_PERF_EN
        check("stall_cycles", stall_cycles, m_stalls);
        check("flush_count", flush_count, m_flushes);
`else
        check("stall_cycles", stall_cycles, 0);
        check("flush_count", flush_count, 0);
`endif
        // advance the model to what holds after the coming rising edge
        if (rst_n) begin
            if (!m_exp[6]) m_stalls++;
            if (m_exp[0])  m_flushes++;
            if (m_err) begin
                m_err = 1;
            end else if (m_waiting) begin
                if (mem_ack) begin
                    m_waiting = 0;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin
                        m_err     = 1;
                        m_waiting = 0;
                    end
                end
            end else if (mem_req_mem && !mem_ack) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic mr, input logic [4:0] rd, input logic br,
                         input logic req, input logic ack);
        @(posedge clk);
        #1;
        opcode_id       = op;
        rs1_id          = r1;
        rs2_id          = r2;
        mem_read_ex     = mr;
        rd_ex           = rd;
        branch_taken_ex = br;
        mem_req_mem     = req;
        mem_ack         = ack;
        #1;
    endtask

    task automatic idle();
        apply(OPIMM, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        #2;
        check("rst_pc_write", pc_write, 1'b0);
        check("rst_mem_wb_write", mem_wb_write, 1'b0);
        check("rst_bubble_flush", {id_ex_bubble, if_id_flush}, 2'b00);
        check("rst_err", mem_timeout_err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("post_rst_we", {pc_write, if_id_write, id_ex_write, ex_mem_write,
                                 mem_wb_write}, 5'b11111);

        // lw x5 in EX, add x6,x5,x1 in ID: one stall cycle
        apply(OP, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        check("lu_pc_write", pc_write, 1'b0);
        check("lu_if_id_write", if_id_write, 1'b0);
        check("lu_bubble", id_ex_bubble, 1'b1);
        check("lu_id_ex_write", id_ex_write, 1'b1);
        idle();
        check("lu_after", {pc_write, id_ex_bubble}, 2'b10);

        // lui x5 in ID: no source read
        apply(LUI, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        check("lui_no_stall", pc_write, 1'b1);
        // lw x0 in EX, add x6,x0,x0 in ID
        apply(OP, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check("x0_no_stall", pc_write, 1'b1);
        // sw: rs2 is a real read
        apply(STORE, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        check("sw_rs2_stall", {pc_write, id_ex_bubble}, 2'b01);
        // addi: the rs2 bits are immediate
        apply(OPIMM, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        check("addi_rs2_ignored", pc_write, 1'b1);
        apply(JAL, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        apply(AUIPC, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        apply(BRANCH, 5'd9, 5'd12, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
        check("beq_rs2_stall", pc_write, 1'b0);
        // load with rs1 match (I format)
        apply(LOAD, 5'd12, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);

        // branch overrides load-use
        apply(OP, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        check("br_lu", {pc_write, id_ex_bubble, if_id_flush}, 3'b111);
        idle();
`ifdef HAZARD_PERF_EN
        check("perf_stalls", stall_cycles, 4);
        check("perf_flushes", flush_count, 1);
`else
        check("perf_stalls_off", stall_cycles, 0);
        check("perf_flushes_off", flush_count, 0);
`endif

        // memory wait acked in the third cycle: exactly three frozen cycles
        apply(OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("mw_c1", {pc_write, mem_wb_write, if_id_flush}, 3'b000);
        apply(OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("mw_c2", {pc_write, mem_wb_write}, 2'b00);
        // taken branch arrives while frozen: held back
        apply(OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("mw_c3_frozen", {pc_write, mem_wb_write, if_id_flush}, 3'b000);
        apply(OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        check("mw_branch_late", {pc_write, if_id_flush}, 2'b11);
        idle();

        // same-cycle ack: no freeze, no state change
        apply(OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("ack_same_cycle", {pc_write, mem_wb_write}, 2'b11);
        idle();
        check("ack_same_after", pc_write, 1'b1);

        // never acked: timeout after TIMEOUT wait cycles
        apply(OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            apply(OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            check("to_pending", mem_timeout_err, 1'b0);
        end
        idle();
        check("to_set", mem_timeout_err, 1'b1);
        check("to_frozen", pc_write, 1'b0);
        idle();
        apply(OP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("to_sticky", {mem_timeout_err, pc_write}, 2'b10);

        // asynchronous reset clears the error without a clock edge
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_clr", {mem_timeout_err, pc_write}, 2'b00);
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rerun", {mem_timeout_err, pc_write}, 2'b01);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
